// File: rtl/step_loader.sv
// rtl/step_loader.sv - deserialises the 32-bit witness stream into double-buffered step records
//
// Purpose:
//   Collects one frame of witness words (raw instruction, eight GPRs, two
//   memory hints) and presents it as a complete step record through a
//   one-entry output register with a valid/ready handshake. The next frame
//   assembles in staging while the current record waits for its consumer.
//
// Optional feature:
//   STEP_CHECK_EN - frame grows to 18 words; w17 must equal the XOR of
//   w0..w16 or the record is dropped and frame_err is set (sticky).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_word  witness word stream
//   out_valid/out_ready      step record handshake
//   raw_instr                instruction bytes, first byte in [95:88]
//   eax..ebp                 register file snapshot
//   hint{1,2}_rw/address/data  memory hints (rw 1 = write)
//   step_count               records handed off, wraps
//   frame_err                sticky checksum error (0 without STEP_CHECK_EN)

module step_loader #(
    parameter int STEP_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [95:0]           raw_instr,
    output logic [31:0]           eax,
    output logic [31:0]           ebx,
    output logic [31:0]           ecx,
    output logic [31:0]           edx,
    output logic [31:0]           esi,
    output logic [31:0]           edi,
    output logic [31:0]           esp,
    output logic [31:0]           ebp,
    output logic                  hint1_rw,
    output logic [31:0]           hint1_address,
    output logic [31:0]           hint1_data,
    output logic                  hint2_rw,
    output logic [31:0]           hint2_address,
    output logic [31:0]           hint2_data,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic                  frame_err
);

`ifdef STEP_CHECK_EN
    localparam logic [4:0] LAST_IDX = 5'd17;
`else
    localparam logic [4:0] LAST_IDX = 5'd16;
`endif

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic [31:0] stg [0:16];
    logic [31:0] src [0:16];

    logic accept;
    logic last_word;
    logic chk_ok;
    logic frame_done;
    logic out_free;
    logic handoff;
    logic load;

    assign in_ready   = (state == FILL);
    assign accept     = in_valid && in_ready;
    assign last_word  = accept && (idx == LAST_IDX);
    assign out_free   = !out_valid || out_ready;
    assign handoff    = out_valid && out_ready;
    assign frame_done = last_word && chk_ok;
    // Either the just-completed frame goes straight out, or a held frame
    // leaves staging; both cannot happen together since HOLD blocks input.
    assign load       = out_free && (frame_done || (state == HOLD));

`ifdef STEP_CHECK_EN
    logic [31:0] xor_acc;

    assign chk_ok = (xor_acc == in_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            xor_acc   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                xor_acc <= last_word ? 32'd0 : (xor_acc ^ in_word);
            end
            if (last_word && !chk_ok) begin
                frame_err <= 1'b1;
            end
        end
    end
`else
    assign chk_ok    = 1'b1;
    assign frame_err = 1'b0;
`endif

    // Record source: staging, except that without the checksum word the
    // last data word bypasses staging when the frame completes in FILL.
    always_comb begin
        for (int i = 0; i < 17; i++) begin
            src[i] = stg[i];
        end
`ifndef STEP_CHECK_EN
        if (state == FILL) begin
            src[16] = in_word;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (frame_done && !out_free) state_nxt = HOLD;
            HOLD: if (out_free) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
            for (int i = 0; i < 17; i++) begin
                stg[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx <= last_word ? 5'd0 : (idx + 5'd1);
                if (idx <= 5'd16) begin
                    stg[idx] <= in_word;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            step_count    <= '0;
            raw_instr     <= '0;
            eax           <= '0;
            ebx           <= '0;
            ecx           <= '0;
            edx           <= '0;
            esi           <= '0;
            edi           <= '0;
            esp           <= '0;
            ebp           <= '0;
            hint1_rw      <= 1'b0;
            hint1_address <= '0;
            hint1_data    <= '0;
            hint2_rw      <= 1'b0;
            hint2_address <= '0;
            hint2_data    <= '0;
        end else begin
            if (handoff) begin
                step_count <= step_count + STEP_CNT_W'(1);
            end
            if (load) begin
                out_valid     <= 1'b1;
                raw_instr     <= {src[0], src[1], src[2]};
                eax           <= src[3];
                ebx           <= src[4];
                ecx           <= src[5];
                edx           <= src[6];
                esi           <= src[7];
                edi           <= src[8];
                esp           <= src[9];
                ebp           <= src[10];
                hint1_rw      <= src[11][0];
                hint1_address <= src[12];
                hint1_data    <= src[13];
                hint2_rw      <= src[14][0];
                hint2_address <= src[15];
                hint2_data    <= src[16];
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_loader.sv
// tb/tb_step_loader.sv - randomized self-checking bench for step_loader with a record-level model

module tb_step_loader;

    localparam int CW = 2;
`ifdef STEP_CHECK_EN
    localparam int FLEN = 18;
`else
    localparam int FLEN = 17;
`endif

    typedef logic [16:0][31:0] rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_word = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [95:0]   raw_instr;
    logic [31:0]   eax, ebx, ecx, edx, esi, edi, esp, ebp;
    logic          hint1_rw, hint2_rw;
    logic [31:0]   hint1_address, hint1_data, hint2_address, hint2_data;
    logic [CW-1:0] step_count;
    logic          frame_err;

    int tests = 0;
    int fails = 0;
    bit rdy_rand = 1'b0;

    step_loader #(.STEP_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .raw_instr(raw_instr),
        .eax(eax), .ebx(ebx), .ecx(ecx), .edx(edx),
        .esi(esi), .edi(edi), .esp(esp), .ebp(ebp),
        .hint1_rw(hint1_rw), .hint1_address(hint1_address), .hint1_data(hint1_data),
        .hint2_rw(hint2_rw), .hint2_address(hint2_address), .hint2_data(hint2_data),
        .step_count(step_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    rec_t dut_rec;
    assign dut_rec = {hint2_data, hint2_address, {31'b0, hint2_rw},
                      hint1_data, hint1_address, {31'b0, hint1_rw},
                      ebp, esp, edi, esi, edx, ecx, ebx, eax,
                      raw_instr[31:0], raw_instr[63:32], raw_instr[95:64]};

    task automatic chk(input string name, input logic [543:0] act, input logic [543:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model (record level) ----------------
    bit            m_init = 1'b0;
    bit            m_valid, m_held, m_err;
    rec_t          m_rec, m_held_rec;
    logic [CW-1:0] m_cnt;
    logic [31:0]   m_words[$];

    function automatic rec_t make_rec(input logic [31:0] w[$]);
        rec_t r;
        for (int i = 0; i < 17; i++) r[i] = w[i];
        r[11] = {31'b0, w[11][0]};
        r[14] = {31'b0, w[14][0]};
        return r;
    endfunction

    task automatic model_step();
        bit nv, free, ok;
        rec_t nrec;
        logic [31:0] x;
        if (rst) begin
            m_init = 1'b1; m_valid = 0; m_held = 0; m_err = 0;
            m_rec = '0; m_cnt = '0; m_words.delete();
        end else if (m_init) begin
            free = !m_valid || out_ready;
            nv = m_valid && !out_ready;
            nrec = m_rec;
            if (m_valid && out_ready) m_cnt = m_cnt + 1'b1;
            if (m_held) begin
                if (free) begin nv = 1; nrec = m_held_rec; m_held = 0; end
            end else if (in_valid) begin
                m_words.push_back(in_word);
                if (m_words.size() == FLEN) begin
                    x = '0;
                    for (int i = 0; i < 17; i++) x ^= m_words[i];
                    ok = (FLEN == 17) || (x == m_words[FLEN-1]);
                    if (!ok) m_err = 1;
                    else if (free) begin nv = 1; nrec = make_rec(m_words); end
                    else begin m_held = 1; m_held_rec = make_rec(m_words); end
                    m_words.delete();
                end
            end
            m_valid = nv;
            m_rec = nrec;
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 544'(in_ready), 544'(!m_held));
            chk("out_valid", 544'(out_valid), 544'(m_valid));
            chk("step_count", 544'(step_count), 544'(m_cnt));
            chk("frame_err", 544'(frame_err), 544'(m_err));
            if (m_valid) chk("record", dut_rec, m_rec);
        end
        model_step();
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic send_word(input logic [31:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 0; in_word = $urandom; @(posedge clk); #1;
        end
        in_valid = 1; in_word = w;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n > 500) begin
                tests++; fails++;
                $display("FAIL send_word_timeout actual=%0b required=1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 0; in_word = $urandom;
    endtask

    // gap_mode: 0 none, 1 one idle cycle per word, 2 random 0..2
    task automatic send_frame(input logic [31:0] w[17], input int gap_mode, input bit corrupt);
        logic [31:0] x;
        int gap;
        x = '0;
        for (int i = 0; i < 17; i++) begin
            gap = (gap_mode == 2) ? $urandom_range(0, 2) : gap_mode;
            send_word(w[i], gap);
            x ^= w[i];
        end
`ifdef STEP_CHECK_EN
        send_word(corrupt ? (x ^ 32'd1) : x, 0);
`else
        if (corrupt) x = '0;
`endif
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        repeat (n) @(posedge clk);
        #1 rst = 0;
    endtask

    function automatic rec_t rec_of(input logic [31:0] w[17]);
        rec_t r;
        for (int i = 0; i < 17; i++) r[i] = w[i];
        r[11] = {31'b0, w[11][0]};
        r[14] = {31'b0, w[14][0]};
        return r;
    endfunction

    logic [31:0] fa[17], fb[17];
    int seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        @(posedge clk); #1;
        do_reset(3);
        chk("reset_valid", 544'(out_valid), 544'(0));
        chk("reset_data", dut_rec, '0);
        chk("reset_count", 544'(step_count), 544'(0));

        // basic frame, consumer always ready
        out_ready = 1;
        for (int i = 0; i < 17; i++) fa[i] = 32'h1000_0000 + 32'(i);
        send_frame(fa, 0, 0);
        chk("t1_valid", 544'(out_valid), 544'(1));
        chk("t1_raw", 544'(raw_instr), 544'(96'h10000000_10000001_10000002));
        chk("t1_eax", 544'(eax), 544'(32'h10000003));
        chk("t1_ebp", 544'(ebp), 544'(32'h1000000A));
        chk("t1_h1rw", 544'(hint1_rw), 544'(1));
        chk("t1_h2data", 544'(hint2_data), 544'(32'h10000010));
        @(posedge clk); #1;
        chk("t1_count", 544'(step_count), 544'(1));

        // backpressure: two frames, second held
        do_reset(2);
        out_ready = 0;
        for (int i = 0; i < 17; i++) begin fa[i] = $urandom; fb[i] = $urandom; end
        send_frame(fa, 0, 0);
        send_frame(fb, 0, 0);
        chk("bp_hold_ready", 544'(in_ready), 544'(0));
        repeat (3) @(posedge clk); #1;
        chk("bp_rec1_stable", dut_rec, rec_of(fa));
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("bp_valid", 544'(out_valid), 544'(1));
        chk("bp_rec2", dut_rec, rec_of(fb));
        chk("bp_ready", 544'(in_ready), 544'(1));
        chk("bp_count", 544'(step_count), 544'(1));
        out_ready = 1;
        repeat (3) @(posedge clk); #1;

        // gapped input
        for (int i = 0; i < 17; i++) fa[i] = $urandom;
        send_frame(fa, 1, 0);
        chk("gap_rec", dut_rec, rec_of(fa));
        send_frame(fa, 0, 0);
        chk("gap_rec_again", dut_rec, rec_of(fa));

        // reset mid-frame, then all-ones frame
        for (int i = 0; i < 8; i++) send_word($urandom, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_valid", 544'(out_valid), 544'(0));
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 17; i++) fa[i] = 32'hFFFF_FFFF;
        send_frame(fa, 0, 0);
        chk("ones_rec", dut_rec, rec_of(fa));
        chk("ones_h2rw", 544'(hint2_rw), 544'(1));

        // counter wrap
        do_reset(2);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 17; i++) fa[i] = $urandom;
            send_frame(fa, 0, 0);
            @(posedge clk); #1;
            chk("wrap_count", 544'(step_count), 544'(seq[k]));
        end

        // randomized traffic with random consumer
        rdy_rand = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 17; i++) fa[i] = $urandom;
            send_frame(fa, 2, 0);
        end
        rdy_rand = 0;
        @(posedge clk); #1;
        out_ready = 1;
        repeat (40) @(posedge clk); #1;

`ifdef STEP_CHECK_EN
        do_reset(2);
        for (int i = 0; i < 17; i++) fa[i] = $urandom;
        send_frame(fa, 0, 0);
        chk("ck_good_valid", 544'(out_valid), 544'(1));
        @(posedge clk); #1;
        send_frame(fa, 0, 1);
        repeat (3) @(posedge clk); #1;
        chk("ck_bad_valid", 544'(out_valid), 544'(0));
        chk("ck_bad_err", 544'(frame_err), 544'(1));
        chk("ck_bad_count", 544'(step_count), 544'(1));
        for (int i = 0; i < 17; i++) fb[i] = $urandom;
        send_frame(fb, 0, 0);
        chk("ck_next_valid", 544'(out_valid), 544'(1));
        chk("ck_next_rec", dut_rec, rec_of(fb));
        chk("ck_next_err", 544'(frame_err), 544'(1));
        repeat (3) @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
